// File: rtl/ofm_pkg.sv
// Shared definitions for the 10GbE transmit frame buffer: FSM encodings,
// descriptor layout and data FIFO word layout (used by ingress and MAC-side reader).
package ofm_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CTRL = 3'd1,
      S_DATA = 3'd2,
      S_STAT = 3'd3
   } ofm_state_e;

   localparam int DFIFO_W     = 73;
   localparam int DFIFO_TLAST = 72;

   localparam int DESC_LEN_LO   = 0;
   localparam int DESC_LEN_HI   = 15;
   localparam int DESC_BEATS_LO = 16;
   localparam int DESC_BEATS_HI = 27;
   localparam int DESC_ERR      = 31;
   localparam int DESC_APP1_LO  = 32;
   localparam int DESC_APP1_HI  = 63;

   function automatic logic [63:0] pack_desc(input logic [15:0] len,
                                             input logic [11:0] beats,
                                             input logic        err,
                                             input logic [31:0] app1);
      logic [63:0] d;
      d = '0;
      d[DESC_LEN_HI:DESC_LEN_LO]     = len;
      d[DESC_BEATS_HI:DESC_BEATS_LO] = beats;
      d[DESC_ERR]                    = err;
      d[DESC_APP1_HI:DESC_APP1_LO]   = app1;
      return d;
   endfunction

endpackage

// File: rtl/ofm_keep_cnt.sv
// Byte-enable analysis for one data beat: number of valid bytes and whether the
// enables form a non-empty LSB-first contiguous run.
module ofm_keep_cnt (
   input  logic [7:0] tkeep,
   output logic [3:0] keep_pop,
   output logic       keep_contig
);

   always_comb begin
      keep_pop = 4'd0;
      for (int i = 0; i < 8; i++) begin
         keep_pop = keep_pop + {3'b000, tkeep[i]};
      end
      // A run 0..n-1 of ones plus one carries into bit n, clearing every set bit.
      keep_contig = (tkeep != 8'h00) && ((tkeep & (tkeep + 8'd1)) == 8'h00);
   end

endmodule

// File: rtl/ofm_in_fsm.sv
// Ingress writer: control words, then data beats into the data FIFO, then one
// descriptor into the ctrl FIFO once the frame's last beat is stored.
module ofm_in_fsm
   import ofm_pkg::*;
#(
   parameter logic [11:0] C_MAX_BEATS  = 12'd1200,
   parameter int          C_CTRL_WORDS = 6
) (
   input  logic                tx_clk,
   input  logic                mm2s_resetn,
   input  logic [31:0]         s_axis_txc_tdata,
   input  logic                s_axis_txc_tvalid,
   input  logic                s_axis_txc_tlast,
   output logic                s_axis_txc_tready,
   input  logic [63:0]         s_axis_txd_tdata,
   input  logic [7:0]          s_axis_txd_tkeep,
   input  logic                s_axis_txd_tvalid,
   input  logic                s_axis_txd_tlast,
   output logic                s_axis_txd_tready,
   output logic [DFIFO_W-1:0]  data_fifo_wdata,
   output logic                data_fifo_wren,
   input  logic                data_fifo_afull,
   output logic [63:0]         ctrl_fifo_wdata,
   output logic                ctrl_fifo_wren,
   input  logic                ctrl_fifo_full,
   output logic [3:0]          ofm_in_fsm_dbg
);

   localparam logic [7:0] CTRL_LAST_IDX = 8'(C_CTRL_WORDS - 1);

   ofm_state_e  state_q, state_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [11:0] beat_cnt_q, beat_cnt_d;
   logic [31:0] app1_q, app1_d;
   logic        err_q, err_d;
   logic [7:0]  idx_q, idx_d;

   logic [3:0]  keep_pop;
   logic        keep_contig;
   logic [16:0] byte_sum;

   ofm_keep_cnt u_keep_cnt (
      .tkeep       (s_axis_txd_tkeep),
      .keep_pop    (keep_pop),
      .keep_contig (keep_contig)
   );

   assign byte_sum = {1'b0, byte_cnt_q} + {13'd0, keep_pop};

   always_ff @(posedge tx_clk or negedge mm2s_resetn) begin
      if (!mm2s_resetn) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         beat_cnt_q <= '0;
         app1_q     <= '0;
         err_q      <= 1'b0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         app1_q     <= app1_d;
         err_q      <= err_d;
         idx_q      <= idx_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      byte_cnt_d        = byte_cnt_q;
      beat_cnt_d        = beat_cnt_q;
      app1_d            = app1_q;
      err_d             = err_q;
      idx_d             = idx_q;
      s_axis_txc_tready = 1'b0;
      s_axis_txd_tready = 1'b0;
      data_fifo_wren    = 1'b0;
      ctrl_fifo_wren    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (s_axis_txc_tvalid) begin
               state_d    = S_CTRL;
               byte_cnt_d = '0;
               beat_cnt_d = '0;
               err_d      = 1'b0;
               idx_d      = '0;
            end
         end
         S_CTRL: begin
            s_axis_txc_tready = 1'b1;
            if (s_axis_txc_tvalid) begin
               idx_d = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;
               if (idx_q == 8'd1) app1_d = s_axis_txc_tdata;
               if (s_axis_txc_tlast) begin
                  state_d = S_DATA;
                  if (idx_q != CTRL_LAST_IDX) err_d = 1'b1;
               end
            end
         end
         S_DATA: begin
            s_axis_txd_tready = ~data_fifo_afull;
            if (s_axis_txd_tvalid && !data_fifo_afull) begin
               data_fifo_wren = 1'b1;
               byte_cnt_d = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
               beat_cnt_d = (beat_cnt_q == 12'hFFF) ? beat_cnt_q : beat_cnt_q + 12'd1;
               // Bad beats are still stored so the frame always ends with tlast.
               if (!s_axis_txd_tlast && (beat_cnt_q >= C_MAX_BEATS - 12'd1)) err_d = 1'b1;
               if (!s_axis_txd_tlast && (s_axis_txd_tkeep != 8'hFF)) err_d = 1'b1;
               if (!keep_contig) err_d = 1'b1;
               if (s_axis_txd_tlast) state_d = S_STAT;
            end
         end
         S_STAT: begin
            ctrl_fifo_wren = ~ctrl_fifo_full;
            if (!ctrl_fifo_full) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign data_fifo_wdata = {s_axis_txd_tlast, s_axis_txd_tkeep, s_axis_txd_tdata};
   assign ctrl_fifo_wdata = pack_desc(byte_cnt_q, beat_cnt_q, err_q, app1_q);
   assign ofm_in_fsm_dbg  = {1'b0, state_q};

endmodule
